// File: rtl/pc_sequencer.sv
// Program-counter sequencer: FETCH -> EXEC -> (STALL) -> FETCH, one retirement per EXEC/STALL exit.
// Data-memory busy parks the resolved next-PC in STALL; instruction-memory busy holds FETCH.
module pc_sequencer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        imem_busywait_i,
  input  logic        jump_i,
  input  logic        branch_i,
  input  logic        zero_i,
  input  logic [7:0]  offset_i,
  input  logic        dmem_busywait_i,
  output logic [31:0] pc_o,
  output logic        imem_read_o,
  output logic        instr_valid_o,
  output logic        pc_select_o,
  output logic [31:0] pc_next_o,
  output logic [15:0] instr_count_o
);

  typedef enum logic [1:0] {FETCH, EXEC, STALL} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] lat_next_q, lat_next_d;
  logic        lat_sel_q, lat_sel_d;
  logic [15:0] cnt_q, cnt_d;
  logic        armed_q;

  logic        take;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] exec_next;

  assign pc_plus4  = pc_q + 32'd4;
  assign target    = pc_plus4 + {{22{offset_i[7]}}, offset_i, 2'b00};
  assign take      = jump_i | (branch_i & zero_i);
  assign exec_next = take ? target : pc_plus4;

  assign pc_o          = pc_q;
  assign instr_count_o = cnt_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    lat_next_d    = lat_next_q;
    lat_sel_d     = lat_sel_q;
    cnt_d         = cnt_q;
    imem_read_o   = 1'b0;
    instr_valid_o = 1'b0;
    pc_select_o   = 1'b0;
    pc_next_o     = 32'h0;
    unique case (state_q)
      FETCH: begin
        // armed_q keeps the request low until the first edge after reset release
        imem_read_o = armed_q;
        if (armed_q && !imem_busywait_i) state_d = EXEC;
      end
      EXEC: begin
        instr_valid_o = 1'b1;
        pc_select_o   = take;
        pc_next_o     = exec_next;
        if (dmem_busywait_i) begin
          lat_next_d = exec_next;
          lat_sel_d  = take;
          state_d    = STALL;
        end else begin
          pc_d    = exec_next;
          cnt_d   = cnt_q + 16'd1;
          state_d = FETCH;
        end
      end
      STALL: begin
        pc_select_o = lat_sel_q;
        pc_next_o   = lat_next_q;
        if (!dmem_busywait_i) begin
          pc_d    = lat_next_q;
          cnt_d   = cnt_q + 16'd1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= FETCH;
      pc_q       <= 32'h0;
      lat_next_q <= 32'h0;
      lat_sel_q  <= 1'b0;
      cnt_q      <= 16'h0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      lat_next_q <= lat_next_d;
      lat_sel_q  <= lat_sel_d;
      cnt_q      <= cnt_d;
      armed_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequential flow, branches, wrap, data stall, reset mid-stall, counter wrap.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_busy, jump, branch, zero, dmem_busy;
  logic [7:0]  offset;
  logic [31:0] pc, pc_next;
  logic        imem_read, instr_valid, pc_sel;
  logic [15:0] cnt;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_cnt = 16'h0;

  pc_sequencer dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .imem_busywait_i (imem_busy),
    .jump_i          (jump),
    .branch_i        (branch),
    .zero_i          (zero),
    .offset_i        (offset),
    .dmem_busywait_i (dmem_busy),
    .pc_o            (pc),
    .imem_read_o     (imem_read),
    .instr_valid_o   (instr_valid),
    .pc_select_o     (pc_sel),
    .pc_next_o       (pc_next),
    .instr_count_o   (cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dec();
    jump = 1'b0; branch = 1'b0; zero = 1'b0; offset = 8'h00;
  endtask

  // From FETCH: complete the fetch and land in EXEC.
  task automatic enter_exec();
    imem_busy = 1'b0; dmem_busy = 1'b0;
    clear_dec();
    tick();
  endtask

  // From FETCH: one full instruction with the given decoder outputs and no data stall.
  task automatic retire(input logic j, input logic b, input logic z, input logic [7:0] off);
    enter_exec();
    jump = j; branch = b; zero = z; offset = off;
    tick();
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0;
    clear_dec();
    #3;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h0); end
    total++; if (imem_read !== 1'b0) begin bad++; $display("FAIL rst_imem_read got=%b exp=0", imem_read); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid got=%b exp=0", instr_valid); end
    total++; if (pc_sel !== 1'b0) begin bad++; $display("FAIL rst_pc_sel got=%b exp=0", pc_sel); end
    total++; if (pc_next !== 32'h0) begin bad++; $display("FAIL rst_pc_next got=%h exp=%h", pc_next, 32'h0); end
    total++; if (cnt !== 16'h0) begin bad++; $display("FAIL rst_cnt got=%h exp=%h", cnt, 16'h0); end
    repeat (2) tick();
    total++; if (imem_read !== 1'b0) begin bad++; $display("FAIL rst_held_imem_read got=%b exp=0", imem_read); end
    #3 rst_n = 1'b1;
    #1;
    total++; if (imem_read !== 1'b0) begin bad++; $display("FAIL rst_release_pre_edge got=%b exp=0", imem_read); end
    imem_busy = 1'b1;
    tick();
    total++; if (imem_read !== 1'b1) begin bad++; $display("FAIL rst_first_fetch got=%b exp=1", imem_read); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_first_fetch_pc got=%h exp=%h", pc, 32'h0); end
    exp_cnt = 16'h0;
  endtask

  task automatic test_sequential();
    imem_busy = 1'b1; dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (imem_read !== 1'b1 || instr_valid !== 1'b0 || pc !== 32'h0) begin bad++; $display("FAIL seq_fetch_hold[%0d] got rd=%b v=%b pc=%h exp rd=1 v=0 pc=0", i, imem_read, instr_valid, pc); end
    end
    enter_exec();
    total++; if (instr_valid !== 1'b1 || imem_read !== 1'b0) begin bad++; $display("FAIL seq_exec_flags got v=%b rd=%b exp v=1 rd=0", instr_valid, imem_read); end
    total++; if (pc_sel !== 1'b0 || pc_next !== 32'h4) begin bad++; $display("FAIL seq_exec_next got sel=%b nxt=%h exp sel=0 nxt=%h", pc_sel, pc_next, 32'h4); end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    total++; if (pc !== 32'h4 || cnt !== 16'd1) begin bad++; $display("FAIL seq_first got pc=%h cnt=%0d exp pc=%h cnt=1", pc, cnt, 32'h4); end
    total++; if (imem_read !== 1'b1) begin bad++; $display("FAIL seq_back_to_fetch got=%b exp=1", imem_read); end
    retire(1'b0, 1'b0, 1'b0, 8'h00);
    retire(1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (pc !== 32'hC || cnt !== exp_cnt) begin bad++; $display("FAIL seq_three got pc=%h cnt=%0d exp pc=%h cnt=%0d", pc, cnt, 32'hC, exp_cnt); end
  endtask

  task automatic test_branch();
    retire(1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (pc !== 32'h10) begin bad++; $display("FAIL br_setup got=%h exp=%h", pc, 32'h10); end
    enter_exec();
    branch = 1'b1; zero = 1'b1; offset = 8'h02;
    #1;
    total++; if (pc_sel !== 1'b1 || pc_next !== 32'h1C) begin bad++; $display("FAIL br_taken_next got sel=%b nxt=%h exp sel=1 nxt=%h", pc_sel, pc_next, 32'h1C); end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    total++; if (pc !== 32'h1C) begin bad++; $display("FAIL br_taken_pc got=%h exp=%h", pc, 32'h1C); end
    retire(1'b1, 1'b0, 1'b0, 8'hFC);
    total++; if (pc !== 32'h10) begin bad++; $display("FAIL br_jump_back got=%h exp=%h", pc, 32'h10); end
    enter_exec();
    branch = 1'b1; zero = 1'b0; offset = 8'h02;
    #1;
    total++; if (pc_sel !== 1'b0 || pc_next !== 32'h14) begin bad++; $display("FAIL br_not_taken_next got sel=%b nxt=%h exp sel=0 nxt=%h", pc_sel, pc_next, 32'h14); end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    total++; if (pc !== 32'h14) begin bad++; $display("FAIL br_not_taken_pc got=%h exp=%h", pc, 32'h14); end
    enter_exec();
    jump = 1'b1; branch = 1'b1; zero = 1'b0; offset = 8'hFF;
    #1;
    total++; if (pc_sel !== 1'b1 || pc_next !== 32'h14) begin bad++; $display("FAIL br_jump_and_branch_selfloop got sel=%b nxt=%h exp sel=1 nxt=%h", pc_sel, pc_next, 32'h14); end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    total++; if (pc !== 32'h14 || cnt !== exp_cnt) begin bad++; $display("FAIL br_selfloop_pc got pc=%h cnt=%0d exp pc=%h cnt=%0d", pc, cnt, 32'h14, exp_cnt); end
  endtask

  task automatic test_wrap();
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    exp_cnt = 16'h0;
    total++; if (pc !== 32'h0 || cnt !== 16'h0) begin bad++; $display("FAIL wrap_reset got pc=%h cnt=%0d exp pc=0 cnt=0", pc, cnt); end
    enter_exec();
    jump = 1'b1; offset = 8'hFE;
    #1;
    total++; if (pc_next !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_back_next got=%h exp=%h", pc_next, 32'hFFFFFFFC); end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    total++; if (pc !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_back_pc got=%h exp=%h", pc, 32'hFFFFFFFC); end
    retire(1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_fwd_pc got=%h exp=%h", pc, 32'h0); end
    enter_exec();
    jump = 1'b1; offset = 8'h80;
    #1;
    total++; if (pc_next !== 32'hFFFFFE04) begin bad++; $display("FAIL off_min_next got=%h exp=%h", pc_next, 32'hFFFFFE04); end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    enter_exec();
    jump = 1'b1; offset = 8'h7F;
    #1;
    total++; if (pc_next !== 32'h4) begin bad++; $display("FAIL off_max_next got=%h exp=%h", pc_next, 32'h4); end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    total++; if (pc !== 32'h4 || cnt !== exp_cnt) begin bad++; $display("FAIL off_max_pc got pc=%h cnt=%0d exp pc=%h cnt=%0d", pc, cnt, 32'h4, exp_cnt); end
  endtask

  task automatic test_stall();
    logic [3:0] r;
    retire(1'b1, 1'b0, 1'b0, 8'h06);
    total++; if (pc !== 32'h20) begin bad++; $display("FAIL stall_setup got=%h exp=%h", pc, 32'h20); end
    enter_exec();
    jump = 1'b1; offset = 8'h01; dmem_busy = 1'b1;
    #1;
    total++; if (pc_next !== 32'h28) begin bad++; $display("FAIL stall_exec_next got=%h exp=%h", pc_next, 32'h28); end
    tick();
    total++; if (instr_valid !== 1'b0 || imem_read !== 1'b0) begin bad++; $display("FAIL stall_flags got v=%b rd=%b exp v=0 rd=0", instr_valid, imem_read); end
    total++; if (pc !== 32'h20 || cnt !== exp_cnt) begin bad++; $display("FAIL stall_entry got pc=%h cnt=%0d exp pc=%h cnt=%0d", pc, cnt, 32'h20, exp_cnt); end
    for (int i = 0; i < 4; i++) begin
      r = 4'($urandom);
      jump = r[0]; branch = r[1]; zero = r[2]; offset = 8'($urandom);
      if (i == 3) dmem_busy = 1'b0;
      #1;
      total++; if (pc !== 32'h20 || pc_next !== 32'h28 || pc_sel !== 1'b1) begin bad++; $display("FAIL stall_hold[%0d] got pc=%h nxt=%h sel=%b exp pc=%h nxt=%h sel=1", i, pc, pc_next, pc_sel, 32'h20, 32'h28); end
      tick();
    end
    exp_cnt = exp_cnt + 16'd1;
    total++; if (pc !== 32'h28 || cnt !== exp_cnt || imem_read !== 1'b1) begin bad++; $display("FAIL stall_release got pc=%h cnt=%0d rd=%b exp pc=%h cnt=%0d rd=1", pc, cnt, imem_read, 32'h28, exp_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    enter_exec();
    jump = 1'b1; offset = 8'h05; dmem_busy = 1'b1;
    tick();
    total++; if (pc_next !== 32'h40 || pc !== 32'h28) begin bad++; $display("FAIL rstall_latched got nxt=%h pc=%h exp nxt=%h pc=%h", pc_next, pc, 32'h40, 32'h28); end
    #3 rst_n = 1'b0;
    #1;
    total++; if (pc !== 32'h0 || cnt !== 16'h0 || imem_read !== 1'b0) begin bad++; $display("FAIL rstall_async got pc=%h cnt=%0d rd=%b exp pc=0 cnt=0 rd=0", pc, cnt, imem_read); end
    total++; if (pc_next !== 32'h0 || pc_sel !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL rstall_outs got nxt=%h sel=%b v=%b exp nxt=0 sel=0 v=0", pc_next, pc_sel, instr_valid); end
    dmem_busy = 1'b0;
    tick();
    #3 rst_n = 1'b1;
    imem_busy = 1'b1;
    tick();
    exp_cnt = 16'h0;
    total++; if (imem_read !== 1'b1 || pc !== 32'h0) begin bad++; $display("FAIL rstall_refetch got rd=%b pc=%h exp rd=1 pc=0", imem_read, pc); end
    retire(1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (pc !== 32'h4 || cnt !== exp_cnt) begin bad++; $display("FAIL rstall_no_stale got pc=%h cnt=%0d exp pc=%h cnt=%0d", pc, cnt, 32'h4, exp_cnt); end
  endtask

  task automatic test_count_wrap();
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    exp_cnt = 16'hFFFE;
    total++; if (cnt !== exp_cnt) begin bad++; $display("FAIL cnt_preload got=%h exp=%h", cnt, exp_cnt); end
    retire(1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_ffff got=%h exp=%h", cnt, 16'hFFFF); end
    retire(1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (cnt !== 16'h0000) begin bad++; $display("FAIL cnt_wrap got=%h exp=%h", cnt, 16'h0000); end
    total++; if (pc !== 32'hC || pc[1:0] !== 2'b00) begin bad++; $display("FAIL cnt_wrap_pc got=%h exp=%h", pc, 32'hC); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_stall();
    test_reset_mid_stall();
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
